// File: rtl/fft4_bfly_sequencer_if.sv
// Bus bundle of the 4-point FFT butterfly sequencer: sample input, twiddles, shared butterfly and result output.
// FFT4_EXC_TRACK_EN adds the bf_exc / out_exc exception-tracking pair.
interface fft4_bfly_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_re;
    logic [31:0] in_im;
    logic [31:0] cfg_w0r;
    logic [31:0] cfg_w0i;
    logic [31:0] cfg_w1r;
    logic [31:0] cfg_w1i;
    logic [31:0] bf_ar;
    logic [31:0] bf_ai;
    logic [31:0] bf_br;
    logic [31:0] bf_bi;
    logic [31:0] bf_wr;
    logic [31:0] bf_wi;
    logic [31:0] bf_sumr;
    logic [31:0] bf_sumi;
    logic [31:0] bf_difr;
    logic [31:0] bf_difi;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_re;
    logic [31:0] out_im;
    logic        busy;
`ifdef FFT4_EXC_TRACK_EN
    logic        bf_exc;
    logic        out_exc;
`endif

    modport master (
        output in_valid, in_re, in_im,
        output cfg_w0r, cfg_w0i, cfg_w1r, cfg_w1i,
        output bf_sumr, bf_sumi, bf_difr, bf_difi,
        output out_ready,
`ifdef FFT4_EXC_TRACK_EN
        output bf_exc,
        input  out_exc,
`endif
        input  in_ready,
        input  bf_ar, bf_ai, bf_br, bf_bi, bf_wr, bf_wi,
        input  out_valid, out_re, out_im, busy
    );

    modport slave (
        input  in_valid, in_re, in_im,
        input  cfg_w0r, cfg_w0i, cfg_w1r, cfg_w1i,
        input  bf_sumr, bf_sumi, bf_difr, bf_difi,
        input  out_ready,
`ifdef FFT4_EXC_TRACK_EN
        input  bf_exc,
        output out_exc,
`endif
        output in_ready,
        output bf_ar, bf_ai, bf_br, bf_bi, bf_wr, bf_wi,
        output out_valid, out_re, out_im, busy
    );
endinterface

// File: rtl/fft4_bfly_sequencer.sv
// Frame controller for a 4-point fp32 FFT sharing one external 2-point butterfly (LOAD -> CALC -> OUT).
// Optional macro FFT4_EXC_TRACK_EN adds a sticky per-frame butterfly exception flag.
module fft4_bfly_sequencer #(
    parameter int BF_LAT = 2
) (
    input logic                  clk,
    input logic                  rst,
    fft4_bfly_sequencer_if.slave bus
);
    localparam int WAIT_W = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BF_LAT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;

    state_t            state_q;
    logic [1:0]        ldCnt_q;
    logic [1:0]        pass_q;
    logic [1:0]        rdIdx_q;
    logic [WAIT_W-1:0] wait_q;
    logic [31:0]       slotRe_q [4];
    logic [31:0]       slotIm_q [4];
    logic [31:0]       w0r_q;
    logic [31:0]       w0i_q;
    logic [31:0]       w1r_q;
    logic [31:0]       w1i_q;

    logic       inReady;
    logic       outValid;
    logic       inCalc;
    logic       inFire;
    logic       outFire;
    logic       capture;
    logic       useW1;
    logic [1:0] aIdx;
    logic [1:0] bIdx;
    logic [1:0] rdSlot;

    // Pass schedule: stage-1 pairs (0,2),(1,3) then stage-2 pairs (0,1),(2,3); only p1 uses W1.
    always_comb begin
        aIdx  = 2'd0;
        bIdx  = 2'd2;
        useW1 = 1'b0;
        case (pass_q)
            2'd1: begin
                aIdx  = 2'd1;
                bIdx  = 2'd3;
                useW1 = 1'b1;
            end
            2'd2: begin
                aIdx = 2'd0;
                bIdx = 2'd1;
            end
            2'd3: begin
                aIdx = 2'd2;
                bIdx = 2'd3;
            end
            default: begin
                aIdx = 2'd0;
                bIdx = 2'd2;
            end
        endcase
    end

    // Every output is forced low while rst is held, even before the first reset edge.
    assign inReady  = !rst && (state_q == LOAD);
    assign outValid = !rst && (state_q == OUT);
    assign inCalc   = !rst && (state_q == CALC);
    assign inFire   = bus.in_valid && inReady;
    assign outFire  = outValid && bus.out_ready;
    assign capture  = (state_q == CALC) && (wait_q == WAIT_LAST);
    assign rdSlot   = {rdIdx_q[0], rdIdx_q[1]};

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.busy      = !rst && (state_q != LOAD);
    assign bus.out_re    = outValid ? slotRe_q[rdSlot] : '0;
    assign bus.out_im    = outValid ? slotIm_q[rdSlot] : '0;
    assign bus.bf_ar     = inCalc ? slotRe_q[aIdx] : '0;
    assign bus.bf_ai     = inCalc ? slotIm_q[aIdx] : '0;
    assign bus.bf_br     = inCalc ? slotRe_q[bIdx] : '0;
    assign bus.bf_bi     = inCalc ? slotIm_q[bIdx] : '0;
    assign bus.bf_wr     = inCalc ? (useW1 ? w1r_q : w0r_q) : '0;
    assign bus.bf_wi     = inCalc ? (useW1 ? w1i_q : w0i_q) : '0;

`ifdef FFT4_EXC_TRACK_EN
    logic excFlag_q;
    assign bus.out_exc = outValid && excFlag_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            ldCnt_q <= 2'd0;
            pass_q  <= 2'd0;
            rdIdx_q <= 2'd0;
            wait_q  <= '0;
            w0r_q   <= '0;
            w0i_q   <= '0;
            w1r_q   <= '0;
            w1i_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                slotRe_q[i] <= '0;
                slotIm_q[i] <= '0;
            end
`ifdef FFT4_EXC_TRACK_EN
            excFlag_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                LOAD: begin
                    if (inFire) begin
                        slotRe_q[ldCnt_q] <= bus.in_re;
                        slotIm_q[ldCnt_q] <= bus.in_im;
                        ldCnt_q           <= ldCnt_q + 2'd1;
                        if (ldCnt_q == 2'd3) begin
                            w0r_q   <= bus.cfg_w0r;
                            w0i_q   <= bus.cfg_w0i;
                            w1r_q   <= bus.cfg_w1r;
                            w1i_q   <= bus.cfg_w1i;
                            pass_q  <= 2'd0;
                            wait_q  <= '0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (capture) begin
                        slotRe_q[aIdx] <= bus.bf_sumr;
                        slotIm_q[aIdx] <= bus.bf_sumi;
                        slotRe_q[bIdx] <= bus.bf_difr;
                        slotIm_q[bIdx] <= bus.bf_difi;
                        wait_q         <= '0;
                        pass_q         <= pass_q + 2'd1;
`ifdef FFT4_EXC_TRACK_EN
                        excFlag_q      <= excFlag_q | bus.bf_exc;
`endif
                        if (pass_q == 2'd3) begin
                            rdIdx_q <= 2'd0;
                            state_q <= OUT;
                        end
                    end else begin
                        wait_q <= wait_q + WAIT_ONE;
                    end
                end
                OUT: begin
                    if (outFire) begin
                        rdIdx_q <= rdIdx_q + 2'd1;
                        if (rdIdx_q == 2'd3) begin
                            ldCnt_q <= 2'd0;
                            state_q <= LOAD;
`ifdef FFT4_EXC_TRACK_EN
                            excFlag_q <= 1'b0;
`endif
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_fft4_bfly_sequencer.sv
// Directed bench for fft4_bfly_sequencer with a real-valued fp32 butterfly model on each bf_* port set.
// Three instances (BF_LAT 1, 2, 3); FFT4_EXC_TRACK_EN enables the exception-flag scenario.
module tb_fft4_bfly_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic        latValid;
    logic [31:0] latRe;
    logic [31:0] latIm;
`ifdef FFT4_EXC_TRACK_EN
    logic expExc = 1'b0;
`endif

    always #5 clk = ~clk;

    fft4_bfly_sequencer_if ifL1();
    fft4_bfly_sequencer_if ifL2();
    fft4_bfly_sequencer_if ifL3();

    fft4_bfly_sequencer #(.BF_LAT(1)) dutL1 (.clk(clk), .rst(rst), .bus(ifL1));
    fft4_bfly_sequencer #(.BF_LAT(2)) dutL2 (.clk(clk), .rst(rst), .bus(ifL2));
    fft4_bfly_sequencer #(.BF_LAT(3)) dutL3 (.clk(clk), .rst(rst), .bus(ifL3));

    // The latency instances run in lockstep from one shared stimulus.
    assign ifL1.in_valid = latValid;
    assign ifL1.in_re    = latRe;
    assign ifL1.in_im    = latIm;
    assign ifL1.cfg_w0r  = 32'h3F800000;
    assign ifL1.cfg_w0i  = 32'h0;
    assign ifL1.cfg_w1r  = 32'h0;
    assign ifL1.cfg_w1i  = 32'hBF800000;
    assign ifL1.out_ready = 1'b1;
    assign ifL3.in_valid = latValid;
    assign ifL3.in_re    = latRe;
    assign ifL3.in_im    = latIm;
    assign ifL3.cfg_w0r  = 32'h3F800000;
    assign ifL3.cfg_w0i  = 32'h0;
    assign ifL3.cfg_w1r  = 32'h0;
    assign ifL3.cfg_w1i  = 32'hBF800000;
    assign ifL3.out_ready = 1'b1;
`ifdef FFT4_EXC_TRACK_EN
    assign ifL1.bf_exc = 1'b0;
    assign ifL3.bf_exc = 1'b0;
`endif

    function automatic real toReal(input logic [31:0] f);
        logic [10:0] e;
        logic [63:0] d;
        e = {3'b000, f[30:23]} + 11'd896;
        if (f[30:23] == 8'd0) d = {f[31], 63'd0};
        else                  d = {f[31], e, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] toBits(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [127:0] bfly(input logic [31:0] ar, ai, br, bi, wr, wi);
        real xr, xi, yr, yi, twr, twi, dr, di;
        xr = toReal(ar);  xi = toReal(ai);
        yr = toReal(br);  yi = toReal(bi);
        twr = toReal(wr); twi = toReal(wi);
        dr = xr - yr;
        di = xi - yi;
        return {toBits(xr + yr), toBits(xi + yi), toBits(dr * twr - di * twi), toBits(dr * twi + di * twr)};
    endfunction

    always_comb {ifL1.bf_sumr, ifL1.bf_sumi, ifL1.bf_difr, ifL1.bf_difi} =
        bfly(ifL1.bf_ar, ifL1.bf_ai, ifL1.bf_br, ifL1.bf_bi, ifL1.bf_wr, ifL1.bf_wi);
    always_comb {ifL2.bf_sumr, ifL2.bf_sumi, ifL2.bf_difr, ifL2.bf_difi} =
        bfly(ifL2.bf_ar, ifL2.bf_ai, ifL2.bf_br, ifL2.bf_bi, ifL2.bf_wr, ifL2.bf_wi);
    always_comb {ifL3.bf_sumr, ifL3.bf_sumi, ifL3.bf_difr, ifL3.bf_difi} =
        bfly(ifL3.bf_ar, ifL3.bf_ai, ifL3.bf_br, ifL3.bf_bi, ifL3.bf_wr, ifL3.bf_wi);

    // sel=0 drives the BF_LAT=2 instance, sel=1 the lockstep latency pair; returns just after edge E.
    task automatic loadFrame(input bit sel, input logic [3:0][31:0] re, input logic [3:0][31:0] im);
        int guard;
        for (int i = 0; i < 4; i++) begin
            if (sel) begin
                latValid = 1'b1; latRe = re[i]; latIm = im[i];
            end else begin
                ifL2.in_valid = 1'b1; ifL2.in_re = re[i]; ifL2.in_im = im[i];
            end
            guard = 0;
            while (!(sel ? (ifL1.in_ready && ifL3.in_ready) : ifL2.in_ready) && guard < 50) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 50) begin
                checks++; errors++;
                $display("[TB] FAIL load_ready slot %0d: in_ready=0, required 1", i);
            end
            @(posedge clk); #1;
        end
        latValid = 1'b0;
        ifL2.in_valid = 1'b0;
    endtask

    task automatic readFrame(input logic [3:0][31:0] expRe, input logic [3:0][31:0] expIm, input string tag);
        int guard;
        ifL2.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            guard = 0;
            while (!ifL2.out_valid && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
            checks++;
            if (ifL2.out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s_valid X%0d: out_valid=%b, required 1", tag, k, ifL2.out_valid);
            end
            checks++;
            if (ifL2.out_re !== expRe[k] || ifL2.out_im !== expIm[k]) begin
                errors++;
                $display("[TB] FAIL %s_X%0d: got %h/%h, required %h/%h", tag, k,
                         ifL2.out_re, ifL2.out_im, expRe[k], expIm[k]);
            end
`ifdef FFT4_EXC_TRACK_EN
            checks++;
            if (ifL2.out_exc !== expExc) begin
                errors++;
                $display("[TB] FAIL %s_exc X%0d: out_exc=%b, required %b", tag, k, ifL2.out_exc, expExc);
            end
`endif
            @(posedge clk); #1;
        end
        checks++;
        if (ifL2.out_valid !== 1'b0 || ifL2.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_drain: out_valid=%b in_ready=%b, required 0/1", tag, ifL2.out_valid, ifL2.in_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (ifL2.in_ready !== 1'b0 || ifL2.out_valid !== 1'b0 || ifL2.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 000",
                     ifL2.in_ready, ifL2.out_valid, ifL2.busy);
        end
        checks++;
        if (ifL2.out_re !== 32'h0 || ifL2.bf_ar !== 32'h0 || ifL2.bf_wr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: out_re=%h bf_ar=%h bf_wr=%h, required 0", ifL2.out_re, ifL2.bf_ar, ifL2.bf_wr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ifL2.in_ready !== 1'b1 || ifL2.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: in_ready=%b busy=%b, required 1/0", ifL2.in_ready, ifL2.busy);
        end
    endtask

    task automatic test_impulse;
        logic [3:0][31:0] re, im, xRe, xIm;
        int lat;
        re = '0; im = '0;
        re[0] = 32'h3F800000; re[2] = 32'hBF800000;
        xRe = '0; xIm = '0;
        xRe[1] = 32'h40000000; xRe[3] = 32'h40000000;
        loadFrame(1'b0, re, im);
        checks++;
        if (ifL2.busy !== 1'b1 || ifL2.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL impulse_busy: busy=%b in_ready=%b, required 1/0", ifL2.busy, ifL2.in_ready);
        end
        lat = 0;
        while (!ifL2.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != 8) begin
            errors++;
            $display("[TB] FAIL impulse_latency: %0d cycles, required 8", lat);
        end
        readFrame(xRe, xIm, "impulse");
    endtask

    task automatic test_all_ones;
        logic [3:0][31:0] re, im, xRe, xIm;
        for (int i = 0; i < 4; i++) re[i] = 32'h3F800000;
        im = '0; xRe = '0; xIm = '0;
        xRe[0] = 32'h40800000;
        loadFrame(1'b0, re, im);
        readFrame(xRe, xIm, "ones");
    endtask

    task automatic test_latency;
        logic [3:0][31:0] re, im, expAr, expWi;
        int lat1, lat3;
        re = '0; im = '0;
        re[0] = 32'h3F800000; re[1] = 32'h40000000;
        expAr[0] = 32'h3F800000; expAr[1] = 32'h40000000;
        expAr[2] = 32'h3F800000; expAr[3] = 32'h3F800000;
        expWi = '0;
        expWi[1] = 32'hBF800000;
        lat1 = -1; lat3 = -1;
        loadFrame(1'b1, re, im);
        for (int k = 0; k < 16; k++) begin
            if (k < 4) begin
                checks++;
                if (ifL1.bf_ar !== expAr[k] || ifL1.bf_wi !== expWi[k]) begin
                    errors++;
                    $display("[TB] FAIL lat1_operand cyc %0d: ar=%h wi=%h, required %h/%h", k, ifL1.bf_ar, ifL1.bf_wi, expAr[k], expWi[k]);
                end
            end
            if (k < 12) begin
                checks++;
                if (ifL3.bf_ar !== expAr[k/3] || ifL3.bf_wi !== expWi[k/3]) begin
                    errors++;
                    $display("[TB] FAIL lat3_operand cyc %0d: ar=%h wi=%h, required %h/%h", k, ifL3.bf_ar, ifL3.bf_wi, expAr[k/3], expWi[k/3]);
                end
            end
            if (lat1 < 0 && ifL1.out_valid) begin
                lat1 = k;
                checks++;
                if (ifL1.out_re !== 32'h40400000 || ifL1.out_im !== 32'h0) begin
                    errors++;
                    $display("[TB] FAIL lat1_X0: got %h/%h, required 40400000/00000000", ifL1.out_re, ifL1.out_im);
                end
            end
            if (lat3 < 0 && ifL3.out_valid) begin
                lat3 = k;
                checks++;
                if (ifL3.out_re !== 32'h40400000 || ifL3.out_im !== 32'h0) begin
                    errors++;
                    $display("[TB] FAIL lat3_X0: got %h/%h, required 40400000/00000000", ifL3.out_re, ifL3.out_im);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (lat1 != 4) begin
            errors++;
            $display("[TB] FAIL lat1_latency: %0d cycles, required 4", lat1);
        end
        checks++;
        if (lat3 != 12) begin
            errors++;
            $display("[TB] FAIL lat3_latency: %0d cycles, required 12", lat3);
        end
    endtask

    // Input x = [1, j, 0, 0] gives four distinct results: X = [1+j, 2, 1-j, 0].
    task automatic test_backpressure;
        logic [3:0][31:0] re, im;
        int guard;
        re = '0; im = '0;
        re[0] = 32'h3F800000; im[1] = 32'h3F800000;
        ifL2.out_ready = 1'b0;
        loadFrame(1'b0, re, im);
        ifL2.cfg_w1r = 32'h12345678;
        ifL2.cfg_w1i = 32'h0BADF00D;
        guard = 0;
        while (!ifL2.out_valid && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (ifL2.out_valid !== 1'b1 || ifL2.out_re !== 32'h3F800000 || ifL2.out_im !== 32'h3F800000) begin
            errors++;
            $display("[TB] FAIL bp_X0: valid=%b got %h/%h, required 1 3f800000/3f800000", ifL2.out_valid, ifL2.out_re, ifL2.out_im);
        end
        ifL2.out_ready = 1'b1;
        @(posedge clk); #1;
        ifL2.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) ifL2.out_ready = 1'b1;
            checks++;
            if (ifL2.out_valid !== 1'b1 || ifL2.out_re !== 32'h40000000 || ifL2.out_im !== 32'h0 || ifL2.in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold_X1 cyc %0d: valid=%b got %h/%h in_ready=%b, required 1 40000000/00000000 0",
                         c, ifL2.out_valid, ifL2.out_re, ifL2.out_im, ifL2.in_ready);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (ifL2.out_re !== 32'h3F800000 || ifL2.out_im !== 32'hBF800000) begin
            errors++;
            $display("[TB] FAIL bp_X2: got %h/%h, required 3f800000/bf800000", ifL2.out_re, ifL2.out_im);
        end
        @(posedge clk); #1;
        checks++;
        if (ifL2.out_valid !== 1'b1 || ifL2.out_re !== 32'h0 || ifL2.out_im !== 32'h0 || ifL2.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_X3: valid=%b got %h/%h in_ready=%b, required 1 0/0 0", ifL2.out_valid, ifL2.out_re, ifL2.out_im, ifL2.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (ifL2.out_valid !== 1'b0 || ifL2.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_drain: out_valid=%b in_ready=%b, required 0/1", ifL2.out_valid, ifL2.in_ready);
        end
        ifL2.cfg_w1r = 32'h0;
        ifL2.cfg_w1i = 32'hBF800000;
    endtask

    task automatic test_reset_mid;
        logic [3:0][31:0] re, im;
        for (int i = 0; i < 4; i++) re[i] = 32'h3F800000;
        im = '0;
        loadFrame(1'b0, re, im);
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (ifL2.busy !== 1'b1 || ifL2.bf_wi !== 32'hBF800000) begin
            errors++;
            $display("[TB] FAIL mid_p1: busy=%b bf_wi=%h, required 1/bf800000", ifL2.busy, ifL2.bf_wi);
        end
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (ifL2.in_ready !== 1'b0 || ifL2.out_valid !== 1'b0 || ifL2.busy !== 1'b0 ||
                ifL2.bf_ar !== 32'h0 || ifL2.bf_wi !== 32'h0 || ifL2.out_re !== 32'h0) begin
                errors++;
                $display("[TB] FAIL mid_rst_outputs %0d: in_ready=%b out_valid=%b busy=%b bf_ar=%h bf_wi=%h out_re=%h, required all 0",
                         c, ifL2.in_ready, ifL2.out_valid, ifL2.busy, ifL2.bf_ar, ifL2.bf_wi, ifL2.out_re);
            end
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (ifL2.in_ready !== 1'b1 || ifL2.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_release: in_ready=%b busy=%b, required 1/0", ifL2.in_ready, ifL2.busy);
        end
        test_all_ones();
    endtask

`ifdef FFT4_EXC_TRACK_EN
    task automatic test_exc_track;
        logic [3:0][31:0] re, im, xRe, xIm;
        for (int i = 0; i < 4; i++) re[i] = 32'h3F800000;
        im = '0; xRe = '0; xIm = '0;
        xRe[0] = 32'h40800000;
        loadFrame(1'b0, re, im);
        repeat (5) begin @(posedge clk); #1; end
        ifL2.bf_exc = 1'b1;
        @(posedge clk); #1;
        ifL2.bf_exc = 1'b0;
        expExc = 1'b1;
        readFrame(xRe, xIm, "exc_set");
        expExc = 1'b0;
        loadFrame(1'b0, re, im);
        readFrame(xRe, xIm, "exc_clean");
    endtask
`endif

    initial begin
        rst = 1'b1;
        latValid = 1'b0; latRe = '0; latIm = '0;
        ifL2.in_valid = 1'b0; ifL2.in_re = '0; ifL2.in_im = '0;
        ifL2.cfg_w0r = 32'h3F800000; ifL2.cfg_w0i = 32'h0;
        ifL2.cfg_w1r = 32'h0;        ifL2.cfg_w1i = 32'hBF800000;
        ifL2.out_ready = 1'b0;
`ifdef FFT4_EXC_TRACK_EN
        ifL2.bf_exc = 1'b0;
`endif
        test_reset();
        test_impulse();
        test_all_ones();
        test_latency();
        test_backpressure();
        test_reset_mid();
`ifdef FFT4_EXC_TRACK_EN
        test_exc_track();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
